// File: rtl/fir_pkg.sv
// Shared constants, types and coefficient set for the folded FIR datapath.
// Coefficients are a symmetric Q1.15 low-pass whose DC gain is slightly above unity.
package fir_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int TAPS       = 16;
  localparam int FOLD       = 4;
  localparam int MACS       = TAPS / FOLD;
  localparam int ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(TAPS);
  localparam int PHASE_W    = (FOLD > 1) ? $clog2(FOLD) : 1;
  localparam int TAP_W      = (TAPS > 1) ? $clog2(TAPS) : 1;

  typedef logic signed [DATA_WIDTH-1:0]   sample_t;
  typedef logic signed [2*DATA_WIDTH-1:0] prod_t;
  typedef logic signed [ACC_WIDTH-1:0]    acc_t;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } run_e;

  // h[0] weights the newest sample.
  localparam sample_t COEF [TAPS] = '{
    -16'sd100,  -16'sd300,  -16'sd200,  16'sd600,
     16'sd1800,  16'sd3500,  16'sd5000, 16'sd6400,
     16'sd6400,  16'sd5000,  16'sd3500, 16'sd1800,
     16'sd600,  -16'sd200,  -16'sd300, -16'sd100
  };

  localparam acc_t SAT_MAX = (acc_t'(1) <<< (DATA_WIDTH - 1)) - acc_t'(1);
  localparam acc_t SAT_MIN = -(acc_t'(1) <<< (DATA_WIDTH - 1));

  // Round half up from Q2.30-scale accumulator to Q1.15, then clamp.
  function automatic sample_t round_sat(input acc_t acc);
    acc_t biased;
    acc_t shifted;
    biased  = acc + (acc_t'(1) <<< (DATA_WIDTH - 2));
    shifted = biased >>> (DATA_WIDTH - 1);
    if (shifted > SAT_MAX) begin
      return sample_t'(SAT_MAX);
    end else if (shifted < SAT_MIN) begin
      return sample_t'(SAT_MIN);
    end else begin
      return sample_t'(shifted);
    end
  endfunction

endpackage

// File: rtl/fir_mac_bank.sv
// Combinational MAC slice: MACS signed multipliers over the coefficient/tap group
// selected by the current phase, summed at full accumulator precision.
module fir_mac_bank
  import fir_pkg::*;
(
  input  logic [PHASE_W-1:0] phase_i,
  input  sample_t            taps_i [TAPS],
  output acc_t               partial_o
);

  prod_t prod [MACS];

  always_comb begin
    logic [TAP_W-1:0] idx;
    idx       = '0;
    partial_o = '0;
    for (int unsigned m = 0; m < MACS; m++) begin
      idx       = TAP_W'(int'(phase_i) * MACS + int'(m));
      prod[m]   = COEF[idx] * taps_i[idx];
      partial_o = partial_o + acc_t'(prod[m]);
    end
  end

endmodule

// File: rtl/folded_fir.sv
// Folded direct-form FIR: one sample requested every FOLD cycles, one tap group
// of MACS products accumulated per cycle, rounded/saturated result every FOLD cycles.
module folded_fir
  import fir_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  sample_in,
  output logic                  sample_out
);

  run_e                run_q;
  logic [PHASE_W-1:0]  phase_q;
  logic [PHASE_W-1:0]  phase_d;
  logic                sample_in_q;
  logic                sample_out_q;
  sample_t             x_q [TAPS];
  sample_t             x_d [TAPS];
  sample_t             taps_sel [TAPS];
  acc_t                acc_q;
  acc_t                acc_sum;
  acc_t                partial;
  sample_t             dout_q;

  // Group 0 is computed during the capture cycle itself, on the delay line as it
  // will look after the shift, so the result is ready exactly FOLD cycles later.
  always_comb begin
    x_d[0] = en ? sample_t'(din) : '0;
    for (int unsigned k = 1; k < TAPS; k++) begin
      x_d[k] = x_q[k-1];
    end
    for (int unsigned k = 0; k < TAPS; k++) begin
      taps_sel[k] = (phase_q == '0) ? x_d[k] : x_q[k];
    end
  end

  always_comb begin
    phase_d = '0;
    if (run_q == ST_RUN) begin
      phase_d = (phase_q == PHASE_W'(FOLD - 1)) ? '0 : phase_q + 1'b1;
    end
  end

  assign acc_sum = ((phase_q == '0) ? '0 : acc_q) + partial;

  fir_mac_bank u_mac_bank (
    .phase_i   (phase_q),
    .taps_i    (taps_sel),
    .partial_o (partial)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      run_q        <= ST_IDLE;
      phase_q      <= '0;
      sample_in_q  <= 1'b0;
      sample_out_q <= 1'b0;
      acc_q        <= '0;
      dout_q       <= '0;
      for (int unsigned k = 0; k < TAPS; k++) begin
        x_q[k] <= '0;
      end
    end else begin
      run_q        <= ST_RUN;
      phase_q      <= phase_d;
      sample_in_q  <= (phase_d == '0);
      sample_out_q <= 1'b0;
      if (sample_in_q) begin
        for (int unsigned k = 0; k < TAPS; k++) begin
          x_q[k] <= x_d[k];
        end
      end
      if (run_q == ST_RUN) begin
        acc_q <= acc_sum;
        if (phase_q == PHASE_W'(FOLD - 1)) begin
          dout_q       <= round_sat(acc_sum);
          sample_out_q <= 1'b1;
        end
      end
    end
  end

  assign dout       = dout_q;
  assign sample_in  = sample_in_q;
  assign sample_out = sample_out_q;

endmodule

// File: tb/tb_folded_fir.sv
// Directed bench for folded_fir: a bit-exact reference model pushes the expected
// result for every captured sample, and each sample_out pops and compares one.
module tb_folded_fir;
  import fir_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  en  = 1'b0;
  logic [DATA_WIDTH-1:0] din = '0;
  logic [DATA_WIDTH-1:0] dout;
  logic                  sample_in;
  logic                  sample_out;

  always #5 clk = ~clk;

  folded_fir dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .din        (din),
    .dout       (dout),
    .sample_in  (sample_in),
    .sample_out (sample_out)
  );

  int                    vectors = 0;
  int                    errors  = 0;
  logic [DATA_WIDTH-1:0] exp_q [$];
  int                    hist [TAPS];
  logic [DATA_WIDTH-1:0] last_dout = '0;
  int                    cyc = 0;
  int                    first_in  = -1;
  int                    first_out = -1;
  bit                    paced = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    logic [DATA_WIDTH-1:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (sample_in && first_in < 0) first_in = cyc;
    if (sample_out) begin
      if (first_out < 0) first_out = cyc;
      if (exp_q.size() == 0) begin
        check("spurious_out", {31'd0, sample_out}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("dout", {16'd0, dout}, {16'd0, e});
      end
      last_dout = dout;
    end else if (rst) begin
      check("dout_hold", {16'd0, dout}, {16'd0, last_dout});
    end
  endtask

  function automatic logic [DATA_WIDTH-1:0] model_push(input logic e, input logic [DATA_WIDTH-1:0] d);
    longint acc;
    longint y;
    for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = e ? int'($signed(d)) : 0;
    acc = 0;
    for (int k = 0; k < TAPS; k++) acc += longint'(COEF[k]) * longint'(hist[k]);
    y = (acc + 64'sd16384) >>> 15;
    if (y > 32767) y = 32767;
    if (y < -32768) y = -32768;
    return DATA_WIDTH'(y);
  endfunction

  task automatic feed(input logic e, input logic [DATA_WIDTH-1:0] d);
    int waited;
    waited = 0;
    while (!sample_in && waited < 2 * FOLD) begin
      tick();
      waited++;
    end
    if (!sample_in) begin
      check("sample_in_timeout", {31'd0, sample_in}, 32'd1);
      return;
    end
    if (paced) check("sample_in_period", waited, FOLD - 1);
    en  = e;
    din = d;
    exp_q.push_back(model_push(e, d));
    tick();
    paced = 1'b1;
  endtask

  task automatic reset_model();
    exp_q.delete();
    for (int k = 0; k < TAPS; k++) hist[k] = 0;
    last_dout = '0;
    paced     = 1'b0;
  endtask

  initial begin
    int waited;
    reset_model();

    // Reset state
    rst = 1'b0;
    repeat (3) tick();
    check("rst_dout", {16'd0, dout}, 32'd0);
    check("rst_sample_in", {31'd0, sample_in}, 32'd0);
    check("rst_sample_out", {31'd0, sample_out}, 32'd0);
    rst = 1'b1;
    tick();
    check("first_sample_in", {31'd0, sample_in}, 32'd1);

    // Impulse, then zeros past the full response
    feed(1'b1, 16'h7FFF);
    repeat (TAPS + 2) feed(1'b1, 16'h0000);
    check("first_out_latency", first_out - first_in, FOLD);

    // All-zero input
    repeat (40) feed(1'b1, 16'h0000);

    // Positive step saturates, then negative step clamps
    repeat (24) feed(1'b1, 16'h7FFF);
    check("sat_hi", {16'd0, last_dout}, 32'h7FFF);
    repeat (24) feed(1'b1, 16'h8000);
    check("sat_lo", {16'd0, last_dout}, 32'h8000);

    // Random stream then flush with en low (din ignored)
    repeat (20) feed(1'b1, DATA_WIDTH'($urandom));
    repeat (TAPS + 1) feed(1'b0, DATA_WIDTH'($urandom));
    check("flush_zero", {16'd0, last_dout}, 32'd0);

    // Reset in phase 2 of an in-flight sample
    repeat (5) feed(1'b1, DATA_WIDTH'($urandom));
    tick();
    rst = 1'b0;
    tick();
    check("midrst_dout", {16'd0, dout}, 32'd0);
    check("midrst_sample_in", {31'd0, sample_in}, 32'd0);
    check("midrst_sample_out", {31'd0, sample_out}, 32'd0);
    reset_model();
    rst = 1'b1;
    tick();
    check("rerelease_sample_in", {31'd0, sample_in}, 32'd1);
    feed(1'b1, 16'h4000);
    repeat (TAPS + 1) feed(1'b1, 16'h0000);
    repeat (6) feed(1'b1, DATA_WIDTH'($urandom));

    // Collect the last pending result
    waited = 0;
    while (exp_q.size() != 0 && waited < 2 * FOLD) begin
      tick();
      waited++;
    end
    check("drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
